// File: rtl/vcop_issue_rx_pkg.sv
// Shared definitions for the vector-coprocessor issue receiver: widths, OP-V
// encodings, FSM states and the scalar-operand classification of an instruction.
package vcop_issue_rx_pkg;

   localparam int unsigned WORD_WIDTH   = 32;
   localparam int unsigned REGFILE_BITS = 5;

   localparam logic [6:0] OPCODE_OPV = 7'b1010111;

   localparam logic [2:0] OPIVV = 3'b000;
   localparam logic [2:0] OPFVV = 3'b001;
   localparam logic [2:0] OPMVV = 3'b010;
   localparam logic [2:0] OPIVI = 3'b011;
   localparam logic [2:0] OPIVX = 3'b100;
   localparam logic [2:0] OPFVF = 3'b101;
   localparam logic [2:0] OPMVX = 3'b110;
   localparam logic [2:0] OPCFG = 3'b111;

   typedef enum logic [1:0] {StIdle, StRd1, StRd2} state_e;

   typedef enum logic [1:0] {ClsNone, ClsRs1, ClsRs1Rs2, ClsIllegal} opclass_e;

   // Which scalar registers an OP-V instruction needs from the core.
   function automatic opclass_e classify(input logic [WORD_WIDTH-1:0] instr);
      opclass_e cls;
      cls = ClsNone;
      unique case (instr[14:12])
         OPIVX, OPMVX: cls = ClsRs1;
         OPFVF:        cls = ClsIllegal;
         OPCFG: begin
            if (!instr[31])                      cls = ClsRs1;
            else if (instr[31:25] == 7'b1000000) cls = ClsRs1Rs2;
            else                                 cls = ClsNone;
         end
         default:      cls = ClsNone;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/vcop_issue_rx_fifo.sv
// Synchronous issue queue holding {instr, rs1_val, rs2_val}; head is read
// straight out of the storage registers.
module vcop_issue_rx_fifo #(
   parameter int unsigned WIDTH = 96,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_rdata = r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/vcop_issue_rx.sv
// Coprocessor-side issue receiver: accepts OP-V instructions, reads their scalar
// operands from the core regfile port, and queues them for vector decode.
module vcop_issue_rx
   import vcop_issue_rx_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic [WORD_WIDTH-1:0]   v_instr,
   output logic                    v_stall,
   output logic [REGFILE_BITS-1:0] v_rd_xreg_addr,
   input  logic [WORD_WIDTH-1:0]   xreg_out,
   output logic                    vi_valid,
   input  logic                    vi_ready,
   output logic [WORD_WIDTH-1:0]   vi_instr,
   output logic [WORD_WIDTH-1:0]   vi_rs1_val,
   output logic [WORD_WIDTH-1:0]   vi_rs2_val,
   output logic                    illegal
);

   state_e                r_state;
   state_e                w_state_nxt;
   logic [WORD_WIDTH-1:0] r_s1_instr;
   logic [WORD_WIDTH-1:0] r_rs1_val;
   logic                  r_illegal;

   opclass_e              w_s1_cls;
   opclass_e              w_in_cls;
   logic                  w_take;
   logic                  w_accept;
   logic                  w_done_rd;
   logic                  w_complete;
   logic [WORD_WIDTH-1:0] w_rs1_cap;
   logic [3*WORD_WIDTH-1:0] w_push_data;
   logic [3*WORD_WIDTH-1:0] w_head;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;

   assign w_s1_cls   = classify(r_s1_instr);
   assign w_in_cls   = classify(v_instr);
   assign w_take     = (v_instr[6:0] == OPCODE_OPV) & ~v_stall;
   assign w_accept   = w_take & (w_in_cls != ClsIllegal);
   assign w_done_rd  = ((r_state == StRd1) && (w_s1_cls != ClsRs1Rs2)) || (r_state == StRd2);
   // Uses the pre-pop count: a pop this edge cannot make room for a push.
   assign w_complete = w_done_rd & ~w_fifo_full;
   assign w_rs1_cap  = ((w_s1_cls == ClsRs1) || (w_s1_cls == ClsRs1Rs2)) ? xreg_out : '0;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state    <= StIdle;
         r_s1_instr <= '0;
         r_rs1_val  <= '0;
         r_illegal  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) r_s1_instr <= v_instr;
         if (r_state == StRd1) r_rs1_val <= w_rs1_cap;
         if (w_take && (w_in_cls == ClsIllegal)) r_illegal <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: if (w_accept) w_state_nxt = StRd1;
         StRd1: begin
            if (w_s1_cls == ClsRs1Rs2) w_state_nxt = StRd2;
            else if (w_complete)       w_state_nxt = w_accept ? StRd1 : StIdle;
         end
         StRd2: if (w_complete) w_state_nxt = w_accept ? StRd1 : StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      v_stall        = (r_state != StIdle) & ~w_complete;
      v_rd_xreg_addr = '0;
      w_push_data    = {r_s1_instr, w_rs1_cap, {WORD_WIDTH{1'b0}}};
      unique case (r_state)
         StRd1: v_rd_xreg_addr = r_s1_instr[19:15];
         StRd2: begin
            v_rd_xreg_addr = r_s1_instr[24:20];
            w_push_data    = {r_s1_instr, r_rs1_val, xreg_out};
         end
         default: v_rd_xreg_addr = '0;
      endcase
   end

   vcop_issue_rx_fifo #(
      .WIDTH (3 * WORD_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .nrst    (nrst),
      .i_push  (w_complete),
      .i_pop   (vi_valid & vi_ready),
      .i_wdata (w_push_data),
      .o_rdata (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign vi_valid = ~w_fifo_empty;
   assign {vi_instr, vi_rs1_val, vi_rs2_val} = w_head;
   assign illegal  = r_illegal;

endmodule

// File: tb/tb_vcop_issue_rx.sv
// Bench for vcop_issue_rx: directed table per operand class, multi-cycle corner
// sequences, then random traffic against a queue-based reference model.
module tb_vcop_issue_rx;
   import vcop_issue_rx_pkg::*;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [31:0] v_instr = '0;
   logic        v_stall;
   logic [4:0]  v_rd_xreg_addr;
   logic [31:0] xreg_out;
   logic        vi_valid;
   logic        vi_ready = 1'b0;
   logic [31:0] vi_instr, vi_rs1_val, vi_rs2_val;
   logic        illegal;

   logic [31:0] regs [32];
   assign xreg_out = regs[v_rd_xreg_addr];

   always #5 clk = ~clk;

   vcop_issue_rx #(.FIFO_DEPTH(4)) dut (
      .clk            (clk),
      .nrst           (nrst),
      .v_instr        (v_instr),
      .v_stall        (v_stall),
      .v_rd_xreg_addr (v_rd_xreg_addr),
      .xreg_out       (xreg_out),
      .vi_valid       (vi_valid),
      .vi_ready       (vi_ready),
      .vi_instr       (vi_instr),
      .vi_rs1_val     (vi_rs1_val),
      .vi_rs2_val     (vi_rs2_val),
      .illegal        (illegal)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
      bit          two;
   } vec_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
   } ent_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b1010111};
   endfunction

   // Operand needs straight from the funct3 / top-bit rules.
   task automatic needs(input logic [31:0] ins, output bit n1, output bit n2, output bit ill);
      n1 = 0; n2 = 0; ill = 0;
      if (ins[14:12] == 3'd4 || ins[14:12] == 3'd6) n1 = 1;
      if (ins[14:12] == 3'd5) ill = 1;
      if (ins[14:12] == 3'd7) begin
         if (ins[31] == 1'b0) n1 = 1;
         if (ins[31:25] == 7'h40) begin n1 = 1; n2 = 1; end
      end
   endtask

   function automatic logic [31:0] gen();
      logic [31:0] r;
      int          sel;
      r   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) return 32'h0;
      if (sel == 1) return 32'h00000013;
      r[6:0] = 7'b1010111;
      if (r[14:12] == 3'b111) begin
         case ($urandom_range(0, 3))
            0: r[31] = 1'b0;
            1: r[31:30] = 2'b11;
            2: r[31:25] = 7'b1000000;
            default: ;
         endcase
      end
      return r;
   endfunction

   // Present an instruction, hold it while stalled, then withdraw after acceptance.
   task automatic issue_wait(input logic [31:0] ins, input string nm);
      int cyc;
      cyc = 0;
      v_instr = ins;
      while (v_stall && cyc < 20) begin tick(); cyc++; end
      if (v_stall) timeout(nm);
      tick();
      v_instr = '0;
   endtask

   vec_t        vecs [7];
   logic [31:0] fill [6];
   logic [31:0] got [$];
   ent_t        exp_q [$];

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
      regs[0] = 0; regs[3] = 32'h8; regs[4] = 32'hC0; regs[5] = 32'h1234;
      regs[7] = 32'hDEADBEEF; regs[9] = 32'h55;

      vecs[0] = '{mk(7'h01, 5'd2, 5'd5, 3'b000, 5'd1), 32'h0,        32'h0,  1'b0};
      vecs[1] = '{mk(7'h01, 5'd2, 5'd5, 3'b100, 5'd1), 32'h1234,     32'h0,  1'b0};
      vecs[2] = '{mk(7'h01, 5'd2, 5'd7, 3'b110, 5'd1), 32'hDEADBEEF, 32'h0,  1'b0};
      vecs[3] = '{mk(7'h00, 5'd3, 5'd9, 3'b111, 5'd1), 32'h55,       32'h0,  1'b0};
      vecs[4] = '{mk(7'h60, 5'd3, 5'd5, 3'b111, 5'd1), 32'h0,        32'h0,  1'b0};
      vecs[5] = '{mk(7'h40, 5'd4, 5'd3, 3'b111, 5'd1), 32'h8,        32'hC0, 1'b1};
      vecs[6] = '{mk(7'h01, 5'd2, 5'd7, 3'b011, 5'd1), 32'h0,        32'h0,  1'b0};

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", {31'b0, v_stall}, 0);
      check("rst_addr", {27'b0, v_rd_xreg_addr}, 0);
      check("rst_valid", {31'b0, vi_valid}, 0);
      check("rst_instr", vi_instr, 0);
      check("rst_rs1", vi_rs1_val, 0);
      check("rst_rs2", vi_rs2_val, 0);
      check("rst_illegal", {31'b0, illegal}, 0);
      @(negedge clk);
      nrst = 1'b1;
      tick();

      // One instruction per operand class, from idle with an empty queue
      for (int k = 0; k < 7; k++) begin
         v_instr = vecs[k].instr;
         check($sformatf("v%0d_idle_stall", k), {31'b0, v_stall}, 0);
         tick();
         v_instr = '0;
         check($sformatf("v%0d_addr1", k), {27'b0, v_rd_xreg_addr}, {27'b0, vecs[k].instr[19:15]});
         check($sformatf("v%0d_stall_rd1", k), {31'b0, v_stall}, {31'b0, vecs[k].two});
         check($sformatf("v%0d_early_valid", k), {31'b0, vi_valid}, 0);
         tick();
         if (vecs[k].two) begin
            check($sformatf("v%0d_addr2", k), {27'b0, v_rd_xreg_addr},
                  {27'b0, vecs[k].instr[24:20]});
            check($sformatf("v%0d_stall_rd2", k), {31'b0, v_stall}, 0);
            check($sformatf("v%0d_early_valid2", k), {31'b0, vi_valid}, 0);
            tick();
         end
         check($sformatf("v%0d_valid", k), {31'b0, vi_valid}, 1);
         check($sformatf("v%0d_instr", k), vi_instr, vecs[k].instr);
         check($sformatf("v%0d_rs1", k), vi_rs1_val, vecs[k].rs1);
         check($sformatf("v%0d_rs2", k), vi_rs2_val, vecs[k].rs2);
         vi_ready = 1'b1;
         tick();
         vi_ready = 1'b0;
         check($sformatf("v%0d_popped", k), {31'b0, vi_valid}, 0);
         check($sformatf("v%0d_addr_idle", k), {27'b0, v_rd_xreg_addr}, 0);
      end

      // Back-to-back fill with decode stalled, then in-order drain
      for (int k = 0; k < 6; k++) fill[k] = mk(7'h01, 5'd2, 5'd1, 3'b000, 5'(k + 10));
      for (int k = 0; k < 5; k++) issue_wait(fill[k], $sformatf("fill_issue%0d", k));
      v_instr = fill[5];
      tick();
      check("fill_stall", {31'b0, v_stall}, 1);
      check("fill_head_valid", {31'b0, vi_valid}, 1);
      check("fill_head", vi_instr, fill[0]);
      vi_ready = 1'b1;
      got.delete();
      for (int c = 0; c < 40 && got.size() < 6; c++) begin
         bool_accept: begin
            logic acc;
            acc = (v_instr == fill[5]) && !v_stall;
            if (vi_valid && vi_ready) got.push_back(vi_instr);
            tick();
            if (acc) v_instr = '0;
         end
      end
      vi_ready = 1'b0;
      tick();
      check("fill_count", got.size(), 6);
      for (int k = 0; k < got.size() && k < 6; k++)
         check($sformatf("fill_order%0d", k), got[k], fill[k]);
      check("fill_empty", {31'b0, vi_valid}, 0);

      // OPFVF is flagged and dropped; non-OP-V is ignored
      check("ill_before", {31'b0, illegal}, 0);
      v_instr = mk(7'h01, 5'd2, 5'd1, 3'b101, 5'd3);
      tick();
      v_instr = 32'h00000013;
      check("ill_set", {31'b0, illegal}, 1);
      check("ill_no_stall", {31'b0, v_stall}, 0);
      tick();
      v_instr = '0;
      check("ill_nonopv_addr", {27'b0, v_rd_xreg_addr}, 0);
      check("ill_nonopv_stall", {31'b0, v_stall}, 0);
      repeat (3) tick();
      check("ill_sticky", {31'b0, illegal}, 1);
      check("ill_not_queued", {31'b0, vi_valid}, 0);

      // Reset during RD2 of a vsetvl
      v_instr = vecs[5].instr;
      tick();
      v_instr = '0;
      tick();
      check("rst_mid_rd2_addr", {27'b0, v_rd_xreg_addr}, 4);
      #2 nrst = 1'b0;
      #1;
      check("rst_mid_stall", {31'b0, v_stall}, 0);
      check("rst_mid_addr", {27'b0, v_rd_xreg_addr}, 0);
      check("rst_mid_valid", {31'b0, vi_valid}, 0);
      check("rst_mid_instr", vi_instr, 0);
      check("rst_mid_illegal", {31'b0, illegal}, 0);
      @(negedge clk);
      nrst = 1'b1;
      tick();
      issue_wait(vecs[1].instr, "post_rst_issue");
      begin
         int c;
         c = 0;
         while (!vi_valid && c < 10) begin tick(); c++; end
      end
      check("post_rst_valid", {31'b0, vi_valid}, 1);
      check("post_rst_instr", vi_instr, vecs[1].instr);
      check("post_rst_rs1", vi_rs1_val, 32'h1234);
      vi_ready = 1'b1;
      tick();
      vi_ready = 1'b0;

      // Random traffic against the queue model
      begin
         bit   model_ill;
         bit   n1, n2, ill;
         logic acc;
         ent_t e;
         model_ill = 0;
         for (int i = 1; i < 32; i++) regs[i] = $urandom;
         v_instr = gen();
         for (int c = 0; c < 3000; c++) begin
            vi_ready = ($urandom_range(0, 3) != 0);
            if (vi_valid && vi_ready) begin
               if (exp_q.size() == 0) begin
                  timeout("rand_unexpected_pop");
               end else begin
                  e = exp_q.pop_front();
                  check("rand_instr", vi_instr, e.instr);
                  check("rand_rs1", vi_rs1_val, e.rs1);
                  check("rand_rs2", vi_rs2_val, e.rs2);
               end
            end
            acc = (v_instr[6:0] == 7'b1010111) && !v_stall;
            if (acc) begin
               needs(v_instr, n1, n2, ill);
               if (ill) model_ill = 1;
               else exp_q.push_back('{v_instr, n1 ? regs[v_instr[19:15]] : 32'h0,
                                      n2 ? regs[v_instr[24:20]] : 32'h0});
            end
            tick();
            if (acc || v_instr[6:0] != 7'b1010111) v_instr = gen();
         end
         v_instr = '0;
         vi_ready = 1'b1;
         for (int c = 0; c < 60 && (vi_valid || exp_q.size() != 0); c++) begin
            if (vi_valid) begin
               if (exp_q.size() == 0) begin
                  timeout("drain_unexpected_pop");
               end else begin
                  e = exp_q.pop_front();
                  check("drain_instr", vi_instr, e.instr);
                  check("drain_rs1", vi_rs1_val, e.rs1);
                  check("drain_rs2", vi_rs2_val, e.rs2);
               end
            end
            tick();
         end
         check("drain_left", exp_q.size(), 0);
         check("drain_valid", {31'b0, vi_valid}, 0);
         check("rand_illegal", {31'b0, illegal}, {31'b0, model_ill});
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
